// File: rtl/sc_level_progress_counter_pkg.sv
// Shared constants and state encoding for the level/progress counter
// and the level state machine that decodes its outputs.
package sc_level_progress_counter_pkg;

  localparam int PROGRESS_TARGET = 20;
  localparam int MAX_LEVEL       = 3;
  localparam int LEVEL_NONE      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sc_level_progress_counter_pause_timer.sv
// Loadable down-counter; o_tc flags a count of zero. The count parks at
// zero rather than wrapping, so o_tc stays set until the next load.
module sc_pause_timer #(
  parameter int PAUSE_WIDTH = 25
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [PAUSE_WIDTH-1:0] i_load_val,
  input  logic                   i_dec,
  output logic                   o_tc
);

  logic [PAUSE_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/sc_level_progress_counter.sv
// Level number and per-level row progress for the level state machine,
// with a fixed inter-level pause that freezes frog input.
//
// state    | meaning
// ST_IDLE  | no game running, waiting for StartGame
// ST_PLAY  | level in progress, frog pulses update progress
// ST_PAUSE | inter-level pause, inputs ignored until timer expires
// ST_DONE  | all levels complete, only reset exits
module sc_level_progress_counter
  import sc_level_progress_counter_pkg::*;
#(
  parameter int PROGRESS_WIDTH  = 5,
  parameter int PROGRESS_TARGET = sc_level_progress_counter_pkg::PROGRESS_TARGET,
  parameter int LEVEL_WIDTH     = 3,
  parameter int MAX_LEVEL       = sc_level_progress_counter_pkg::MAX_LEVEL,
  parameter int PAUSE_CYCLES    = 25000000,
  parameter int PAUSE_WIDTH     = 25
) (
  input  logic                      SC_LEVEL_PROGRESS_CLOCK_50,
  input  logic                      SC_LEVEL_PROGRESS_RESET_InLow,
  input  logic                      SC_LEVEL_PROGRESS_StartGame_In,
  input  logic                      SC_LEVEL_PROGRESS_FrogUp_In,
  input  logic                      SC_LEVEL_PROGRESS_FrogDown_In,
  input  logic                      SC_LEVEL_PROGRESS_FrogDied_In,
  input  logic                      SC_LEVEL_PROGRESS_StartCount_In,
  input  logic                      SC_LEVEL_PROGRESS_LevelFinished_In,
  input  logic                      SC_LEVEL_PROGRESS_FinishedGame_In,
  output logic [LEVEL_WIDTH-1:0]    SC_LEVEL_PROGRESS_CurrentLevel_Out,
  output logic [PROGRESS_WIDTH-1:0] SC_LEVEL_PROGRESS_LvlProgressCount_Out,
  output logic                      SC_LEVEL_PROGRESS_LevelUp_Out,
  output logic                      SC_LEVEL_PROGRESS_Pause_Out
);

  localparam logic [PROGRESS_WIDTH-1:0] LP_TARGET   = PROGRESS_WIDTH'(PROGRESS_TARGET);
  localparam logic [LEVEL_WIDTH-1:0]    LP_LVL_END  = LEVEL_WIDTH'(MAX_LEVEL + 1);
  localparam logic [LEVEL_WIDTH-1:0]    LP_LVL_NONE = LEVEL_WIDTH'(LEVEL_NONE);
  localparam logic [PAUSE_WIDTH-1:0]    LP_PAUSE_LD = PAUSE_WIDTH'(PAUSE_CYCLES - 1);

  state_e                    r_state;
  logic [LEVEL_WIDTH-1:0]    r_level;
  logic [PROGRESS_WIDTH-1:0] r_progress;
  logic                      r_level_up;
  logic                      r_pause;

  logic [PROGRESS_WIDTH-1:0] w_progress_nxt;
  logic [LEVEL_WIDTH-1:0]    w_level_inc;
  logic                      w_last_level;
  logic                      w_tmr_load;
  logic                      w_tmr_dec;
  logic                      w_tmr_tc;

  assign w_level_inc  = r_level + 1'b1;
  assign w_last_level = (w_level_inc == LP_LVL_END);
  assign w_tmr_load   = (r_state == ST_PLAY) && SC_LEVEL_PROGRESS_LevelFinished_In && !w_last_level;
  assign w_tmr_dec    = (r_state == ST_PAUSE);

  sc_pause_timer #(
    .PAUSE_WIDTH(PAUSE_WIDTH)
  ) u_pause_timer (
    .i_clk      (SC_LEVEL_PROGRESS_CLOCK_50),
    .i_rst_n    (SC_LEVEL_PROGRESS_RESET_InLow),
    .i_load     (w_tmr_load),
    .i_load_val (LP_PAUSE_LD),
    .i_dec      (w_tmr_dec),
    .o_tc       (w_tmr_tc)
  );

  // Priority: clear requests beat simultaneous up/down, which cancel out.
  always_comb begin
    w_progress_nxt = r_progress;
    if (SC_LEVEL_PROGRESS_StartCount_In || SC_LEVEL_PROGRESS_FrogDied_In) begin
      w_progress_nxt = '0;
    end else if (SC_LEVEL_PROGRESS_FrogUp_In && SC_LEVEL_PROGRESS_FrogDown_In) begin
      w_progress_nxt = r_progress;
    end else if (SC_LEVEL_PROGRESS_FrogUp_In) begin
      w_progress_nxt = (r_progress >= LP_TARGET) ? LP_TARGET : r_progress + 1'b1;
    end else if (SC_LEVEL_PROGRESS_FrogDown_In) begin
      w_progress_nxt = (r_progress == '0) ? '0 : r_progress - 1'b1;
    end
  end

  always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50 or negedge SC_LEVEL_PROGRESS_RESET_InLow) begin
    if (!SC_LEVEL_PROGRESS_RESET_InLow) begin
      r_state    <= ST_IDLE;
      r_level    <= LP_LVL_NONE;
      r_progress <= '0;
      r_level_up <= 1'b0;
      r_pause    <= 1'b1;
    end else begin
      r_level_up <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_level    <= LP_LVL_NONE;
          r_progress <= '0;
          r_pause    <= 1'b1;
          if (SC_LEVEL_PROGRESS_StartGame_In) begin
            r_state <= ST_PLAY;
            r_level <= LEVEL_WIDTH'(1);
            r_pause <= 1'b0;
          end
        end
        ST_PLAY: begin
          r_progress <= w_progress_nxt;
          if (SC_LEVEL_PROGRESS_LevelFinished_In) begin
            r_level    <= w_level_inc;
            r_level_up <= 1'b1;
            r_pause    <= 1'b1;
            r_state    <= w_last_level ? ST_DONE : ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          r_progress <= '0;
          r_pause    <= 1'b1;
          if (w_tmr_tc) begin
            r_state <= ST_PLAY;
            r_pause <= 1'b0;
          end
        end
        ST_DONE: begin
          r_level    <= LP_LVL_END;
          r_progress <= '0;
          r_pause    <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_level    <= LP_LVL_NONE;
          r_progress <= '0;
          r_pause    <= 1'b1;
        end
      endcase
    end
  end

  // Endgame indication from the state machine is only legal once DONE.
  a_finished_game_only_in_done: assert property (
    @(posedge SC_LEVEL_PROGRESS_CLOCK_50) disable iff (!SC_LEVEL_PROGRESS_RESET_InLow)
    (r_state != ST_DONE) |-> SC_LEVEL_PROGRESS_FinishedGame_In
  );

  assign SC_LEVEL_PROGRESS_CurrentLevel_Out     = r_level;
  assign SC_LEVEL_PROGRESS_LvlProgressCount_Out = r_progress;
  assign SC_LEVEL_PROGRESS_LevelUp_Out          = r_level_up;
  assign SC_LEVEL_PROGRESS_Pause_Out            = r_pause;

endmodule

// File: tb/tb_sc_level_progress_counter.sv
// Bench for sc_level_progress_counter: vector table, directed corner
// sequences and randomized traffic against a behavioural game model.
module tb_sc_level_progress_counter;

  localparam int PW   = 5;
  localparam int LW   = 3;
  localparam int TGT  = 20;
  localparam int MAXL = 3;
  localparam int PC   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, up = 1'b0, down = 1'b0, died = 1'b0, sc = 1'b0, lf = 1'b0;
  logic          fg = 1'b1;
  logic [LW-1:0] level;
  logic [PW-1:0] prog;
  logic          lu, pause;

  int n_checks = 0;
  int n_err    = 0;

  // Game model: level 0 = idle, MAXL+1 = over, pause_left = pause cycles still owed.
  int m_level, m_prog, m_pause_left;
  int m_lu;

  always #5 clk = ~clk;

  sc_level_progress_counter #(
    .PROGRESS_WIDTH (PW),
    .PROGRESS_TARGET(TGT),
    .LEVEL_WIDTH    (LW),
    .MAX_LEVEL      (MAXL),
    .PAUSE_CYCLES   (PC),
    .PAUSE_WIDTH    (3)
  ) dut (
    .SC_LEVEL_PROGRESS_CLOCK_50            (clk),
    .SC_LEVEL_PROGRESS_RESET_InLow         (rst_n),
    .SC_LEVEL_PROGRESS_StartGame_In        (start),
    .SC_LEVEL_PROGRESS_FrogUp_In           (up),
    .SC_LEVEL_PROGRESS_FrogDown_In         (down),
    .SC_LEVEL_PROGRESS_FrogDied_In         (died),
    .SC_LEVEL_PROGRESS_StartCount_In       (sc),
    .SC_LEVEL_PROGRESS_LevelFinished_In    (lf),
    .SC_LEVEL_PROGRESS_FinishedGame_In     (fg),
    .SC_LEVEL_PROGRESS_CurrentLevel_Out    (level),
    .SC_LEVEL_PROGRESS_LvlProgressCount_Out(prog),
    .SC_LEVEL_PROGRESS_LevelUp_Out         (lu),
    .SC_LEVEL_PROGRESS_Pause_Out           (pause)
  );

  typedef struct {
    bit s, u, d, di, c, l;
    int e_level, e_prog, e_lu, e_pause;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_pause();
    return (m_level == 0 || m_level == MAXL + 1 || m_pause_left > 0) ? 1 : 0;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, " level"}, int'(level), m_level);
    chk({tag, " progress"}, int'(prog), m_prog);
    chk({tag, " levelup"}, int'(lu), m_lu);
    chk({tag, " pause"}, int'(pause), exp_pause());
  endtask

  task automatic model_reset();
    m_level = 0; m_prog = 0; m_pause_left = 0; m_lu = 0;
  endtask

  task automatic model_step();
    m_lu = 0;
    if (m_level == 0) begin
      if (start) m_level = 1;
    end else if (m_level == MAXL + 1) begin
      m_prog = 0;
    end else if (m_pause_left > 0) begin
      m_pause_left--;
      m_prog = 0;
    end else begin
      if (sc || died)      m_prog = 0;
      else if (up && down) m_prog = m_prog;
      else if (up)         m_prog = (m_prog < TGT) ? m_prog + 1 : TGT;
      else if (down)       m_prog = (m_prog > 0) ? m_prog - 1 : 0;
      if (lf) begin
        m_level++;
        m_lu = 1;
        if (m_level <= MAXL) m_pause_left = PC;
      end
    end
  endtask

  task automatic cycle(input bit s, input bit u, input bit d, input bit di,
                       input bit c, input bit l, input string tag);
    start = s; up = u; down = d; died = di; sc = c; lf = l;
    @(posedge clk);
    #1;
    model_step();
    chk_model(tag);
    start = 0; up = 0; down = 0; died = 0; sc = 0; lf = 0;
    fg = (m_level == MAXL + 1) ? 1'b0 : 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fg = 1'b1;
    start = 0; up = 0; down = 0; died = 0; sc = 0; lf = 0;
    #1;
    model_reset();
    chk_model("reset");
    @(posedge clk);
    #1;
    chk_model("reset hold");
    rst_n = 1'b1;
  endtask

  task automatic wait_pause_end(input string tag);
    int n;
    n = 0;
    while (pause && n < 10) begin
      cycle(0, 0, 0, 0, 0, 0, tag);
      n++;
    end
    if (pause) chk({tag, " pause timeout"}, int'(pause), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   pcount;

    // Table: basic progress rules from reset.
    vt.push_back('{1,0,0,0,0,0, 1,0,0,0});
    vt.push_back('{0,1,0,0,0,0, 1,1,0,0});
    vt.push_back('{0,1,0,0,0,0, 1,2,0,0});
    vt.push_back('{0,1,0,0,0,0, 1,3,0,0});
    vt.push_back('{0,1,0,0,0,0, 1,4,0,0});
    vt.push_back('{0,1,0,0,0,0, 1,5,0,0});
    vt.push_back('{0,1,1,0,0,0, 1,5,0,0});
    vt.push_back('{0,0,1,0,0,0, 1,4,0,0});
    vt.push_back('{1,1,0,0,0,0, 1,5,0,0});
    vt.push_back('{0,1,0,1,0,0, 1,0,0,0});
    vt.push_back('{0,0,1,0,0,0, 1,0,0,0});
    vt.push_back('{0,1,0,0,0,0, 1,1,0,0});
    vt.push_back('{0,1,0,0,1,0, 1,0,0,0});
    vt.push_back('{0,0,1,0,0,0, 1,0,0,0});

    do_reset();
    chk("reset level const", int'(level), 0);
    chk("reset pause const", int'(pause), 1);
    foreach (vt[i]) begin
      cycle(vt[i].s, vt[i].u, vt[i].d, vt[i].di, vt[i].c, vt[i].l, "table");
      chk($sformatf("vec%0d level", i), int'(level), vt[i].e_level);
      chk($sformatf("vec%0d progress", i), int'(prog), vt[i].e_prog);
      chk($sformatf("vec%0d levelup", i), int'(lu), vt[i].e_lu);
      chk($sformatf("vec%0d pause", i), int'(pause), vt[i].e_pause);
    end

    // Fill to the target, saturate, then finish the level.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, "start");
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0, 0, "fill");
    chk("fill to target", int'(prog), 20);
    cycle(0, 1, 0, 0, 0, 0, "sat up");
    chk("saturate at target", int'(prog), 20);
    cycle(0, 0, 0, 0, 1, 1, "finish lvl1");
    chk("lvl2 level", int'(level), 2);
    chk("lvl2 levelup", int'(lu), 1);
    chk("lvl2 progress", int'(prog), 0);
    pcount = int'(pause);
    for (int i = 0; i < 10 && pause; i++) begin
      cycle(0, 1, 0, 0, 1, 1, "pause ignore");
      if (pause) pcount++;
    end
    chk("pause length", pcount, PC);
    chk("level after pause", int'(level), 2);
    chk("levelup after pause", int'(lu), 0);

    // Reset mid-play at level 2, progress 7.
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 0, 0, "to seven");
    chk("progress seven", int'(prog), 7);
    #2;
    rst_n = 1'b0; fg = 1'b1;
    #1;
    model_reset();
    chk("async rst level", int'(level), 0);
    chk("async rst progress", int'(prog), 0);
    chk("async rst pause", int'(pause), 1);
    chk("async rst levelup", int'(lu), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0, 0, "restart");
    chk("restart level", int'(level), 1);
    chk("restart pause", int'(pause), 0);

    // Progress 13 then died.
    for (int i = 0; i < 13; i++) cycle(0, 1, 0, 0, 0, 0, "to thirteen");
    cycle(0, 0, 0, 1, 0, 0, "died");
    chk("died clears", int'(prog), 0);

    // Full run to end of game.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, "start run");
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 1, 0, 0, 1, 1, "complete");
      chk($sformatf("run level %0d", k), int'(level), k + 1);
      if (k < 3) wait_pause_end("run pause");
    end
    chk("done pause", int'(pause), 1);
    cycle(1, 0, 0, 0, 0, 0, "done start");
    cycle(0, 0, 0, 0, 1, 1, "done lf");
    cycle(0, 1, 0, 0, 0, 0, "done up");
    chk("done level held", int'(level), 4);
    chk("done progress", int'(prog), 0);
    chk("done levelup", int'(lu), 0);

    // Randomized traffic against the model.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        bit rs, ru, rd, rdi, rc, rl;
        rs  = ($urandom % 8) == 0;
        ru  = ($urandom % 3) == 0;
        rd  = ($urandom % 4) == 0;
        rdi = ($urandom % 25) == 0;
        rl  = ($urandom % 30) == 0;
        rc  = rl | (($urandom % 20) == 0);
        cycle(rs, ru, rd, rdi, rc, rl, "random");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_level_progress_counter.md
Name: sc_level_progress_counter

Overview:
- Upstream feeder of the level state machine.
- Produces the current level number (0..4) and the per-level row progress count (0..20) that the state machine decodes.
- Consumes the state machine's LevelFinished, StartCount and FinishedGame outputs and the frog-movement pulses from the frog controller.
- Inserts a fixed inter-level pause and freezes frog input during it.

Parameters:
- PROGRESS_WIDTH, 5, width of the progress count.
- PROGRESS_TARGET, 20, rows per level; equals the state machine's finish compare value (12+8).
- LEVEL_WIDTH, 3, width of the level number.
- MAX_LEVEL, 3, last playable level; the level register reaches MAX_LEVEL+1 (= 4) at end of game.
- PAUSE_CYCLES, 25000000, inter-level pause length in clocks (0.5 s at 50 MHz); must be ≥1.
- PAUSE_WIDTH, 25, pause timer width; must satisfy 2^PAUSE_WIDTH > PAUSE_CYCLES.

Ports:
- SC_LEVEL_PROGRESS_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LEVEL_PROGRESS_RESET_InLow  in  1  asynchronous reset, active-low.
- SC_LEVEL_PROGRESS_StartGame_In  in  1  debounced start button, level-sensitive.
- SC_LEVEL_PROGRESS_FrogUp_In  in  1  one-cycle pulse: frog advanced one row.
- SC_LEVEL_PROGRESS_FrogDown_In  in  1  one-cycle pulse: frog retreated one row.
- SC_LEVEL_PROGRESS_FrogDied_In  in  1  one-cycle pulse: collision or drowning.
- SC_LEVEL_PROGRESS_StartCount_In  in  1  from the state machine; 1 = clear and hold progress.
- SC_LEVEL_PROGRESS_LevelFinished_In  in  1  from the state machine; 1 = current level complete.
- SC_LEVEL_PROGRESS_FinishedGame_In  in  1  from the state machine; active-low, 0 = endgame.
- SC_LEVEL_PROGRESS_CurrentLevel_Out  out  LEVEL_WIDTH  level number, 0 = no level.
- SC_LEVEL_PROGRESS_LvlProgressCount_Out  out  PROGRESS_WIDTH  rows gained in the current level.
- SC_LEVEL_PROGRESS_LevelUp_Out  out  1  one-cycle pulse on each level increment.
- SC_LEVEL_PROGRESS_Pause_Out  out  1  1 = frog controller must ignore the joystick.

Behaviour:
Clock and reset:
- Single clock domain; reset is asynchronous, active-low.
- While reset is low: state=IDLE, CurrentLevel=0, LvlProgressCount=0, LevelUp=0, Pause=1, pause timer=0.
- Reset asserted mid-operation aborts any state or pause immediately.
- All outputs are registered; every event becomes visible on the clock edge after it is sampled.

FSM states (IDLE, PLAY, PAUSE, DONE):
- IDLE:
  - Level=0, progress held at 0, Pause=1.
  - StartGame_In=1 -> PLAY; CurrentLevel=1 and Pause=0 at the next edge.
- PLAY:
  - Progress update, evaluated in priority order each cycle:
    1. StartCount_In=1: progress<=0.
    2. Else FrogDied_In=1: progress<=0.
    3. Else FrogUp_In and FrogDown_In both 1: no change.
    4. Else FrogUp_In=1: progress+1, saturating at PROGRESS_TARGET.
    5. Else FrogDown_In=1: progress-1, saturating at 0.
  - LevelFinished_In=1, evaluated in parallel with the progress update:
    - CurrentLevel<=CurrentLevel+1; LevelUp=1 for exactly one cycle.
    - If the new level = MAX_LEVEL+1 -> DONE.
    - Else -> PAUSE, with the timer loaded to PAUSE_CYCLES-1 and Pause=1.
  - The state machine holds LevelFinished for only one cycle, because StartCount clears progress on the same edge. No double increment is possible.
- PAUSE:
  - Pause=1; progress held at 0; frog pulses and StartGame ignored.
  - Timer decrements each cycle; when timer=0 -> PLAY, Pause=0 at the next edge.
  - Duration of Pause=1 is exactly PAUSE_CYCLES clocks.
- DONE:
  - CurrentLevel=MAX_LEVEL+1, progress=0, Pause=1.
  - All inputs ignored; only reset exits.
  - FinishedGame_In=0 is expected here. It is used only for an assertion: FinishedGame_In=0 outside DONE is a protocol error (simulation assertion, no RTL action).
- Unreachable state encodings -> IDLE.

Arithmetic and widths:
- Progress arithmetic is unsigned PROGRESS_WIDTH bits; no wrap-around under any input sequence.
- Level never exceeds MAX_LEVEL+1.

Decomposition:
- Shared package, also usable by the state machine:
  - PROGRESS_TARGET, MAX_LEVEL and LEVEL_NONE=0.
  - State encoding constants IDLE=0, PLAY=1, PAUSE=2, DONE=3 (2-bit).
- One sub-module: sc_pause_timer, a loadable down-counter with a terminal-count flag, PAUSE_WIDTH wide.
- The FSM and the progress/level registers stay in the top module.

Test Plan (PAUSE_CYCLES=4 in simulation):
- Reset low mid-PLAY at level 2, progress 7 -> all outputs return to level 0, progress 0, Pause=1 asynchronously; StartGame then yields level 1 one edge later.
- Start, then 20 FrogUp pulses -> progress reads 20. Drive LevelFinished=1 and StartCount=1 for 1 cycle -> level 2, progress 0, LevelUp high exactly 1 cycle, Pause high exactly 4 cycles, then PLAY.
- Progress 5 with FrogUp and FrogDown in the same cycle -> stays 5. At progress 0, FrogDown -> stays 0. At 20, FrogUp -> stays 20.
- Progress 13, FrogDied pulse -> 0 next edge. FrogDied coincident with FrogUp -> 0.
- Full run through 3 level completions -> level reaches 4, state DONE, Pause=1. Further StartGame and LevelFinished pulses cause no change.
- FrogUp pulses during PAUSE -> progress stays 0. LevelFinished during PAUSE -> level unchanged.
